// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Row-to-bit mapping puts row 000 in the table MSB (Wolfram ordering).
package tt_sweep_pkg;

   localparam int unsigned NUM_ROWS = 8;
   localparam int unsigned TABLE_W  = 8;
   localparam int unsigned ROW_W    = 3;
   localparam int unsigned CNT_W    = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      RESULT
   } state_t;

   // Table bit index holding the sample for a given input row.
   function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] row);
      return ROW_W'(NUM_ROWS - 1) - row;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Result handshake bundle: captured truth table plus match flag.
interface truth_table_sweeper_if;
   import tt_sweep_pkg::*;

   logic               res_valid;
   logic               res_ready;
   logic [TABLE_W-1:0] res_table;
   logic               res_match;

   modport master (
      output res_valid,
      output res_table,
      output res_match,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_table,
      input  res_match,
      output res_ready
   );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Counts enabled cycles; done_o is registered and high during the last of
// SETTLE_CYCLES enabled cycles following a clear.
module settle_timer
   import tt_sweep_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   // done is pre-computed one cycle ahead so the consumer sees a flop output.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (clear_i) begin
         cnt_q  <= '0;
         done_q <= (SETTLE_CYCLES == 32'd1);
      end else if (enable_i) begin
         if (done_q) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
         end else begin
            cnt_q  <= CNT_W'(cnt_q + CNT_W'(1));
            done_q <= (CNT_W'(cnt_q + CNT_W'(1)) == CNT_W'(SETTLE_CYCLES - 1));
         end
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 input rows, captures its output into a
// truth-table word and reports it with a match flag on a valid/ready port.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int unsigned        SETTLE_CYCLES = 4,
   parameter logic [TABLE_W-1:0] EXPECTED      = 8'hCF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   output logic                         busy_o,
   output logic                         gate_in1_o,
   output logic                         gate_in2_o,
   output logic                         gate_in3_o,
   input  logic                         gate_out_i,
   truth_table_sweeper_if.master        res
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

   state_t             state_q;
   logic [ROW_W-1:0]   row_q;
   logic [ROW_W-1:0]   gate_q;
   logic [TABLE_W-1:0] table_q;
   logic               busy_q;
   logic               valid_q;
   logic               match_q;

   logic               clear_c;
   logic               enable_c;
   logic               settle_done;
   logic [TABLE_W-1:0] captured_c;

   // Timer restarts whenever a row begins its settle window.
   assign clear_c  = ((state_q == IDLE) && start_i) ||
                     ((state_q == SAMPLE) && (row_q != LAST_ROW));
   assign enable_c = (state_q == SETTLE);

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (clear_c),
      .enable_i (enable_c),
      .done_o   (settle_done)
   );

   always_comb begin
      captured_c                 = table_q;
      captured_c[row_bit(row_q)] = gate_out_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         gate_q  <= '0;
         table_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q <= SETTLE;
                  row_q   <= '0;
                  gate_q  <= '0;
                  table_q <= '0;
                  match_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            SETTLE: begin
               if (settle_done) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               table_q <= captured_c;
               if (row_q == LAST_ROW) begin
                  state_q <= RESULT;
                  gate_q  <= '0;
                  valid_q <= 1'b1;
                  match_q <= (captured_c == EXPECTED);
               end else begin
                  state_q <= SETTLE;
                  row_q   <= ROW_W'(row_q + ROW_W'(1));
                  gate_q  <= ROW_W'(row_q + ROW_W'(1));
               end
            end
            RESULT: begin
               if (res.res_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign gate_in1_o    = gate_q[2];
   assign gate_in2_o    = gate_q[1];
   assign gate_in3_o    = gate_q[0];
   assign res.res_valid = valid_q;
   assign res.res_table = table_q;
   assign res.res_match = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a default instance (S=4) with a
// selectable gate model and an S=1 instance driving a register-delayed gate.
module tb_truth_table_sweeper;

   typedef struct {
      logic [7:0] tbl;
      logic       m;
      int         vc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic start4, start1;
   logic busy4, busy1;
   logic a4, b4, c4, a1, b1, c1;
   logic g4, g1;
   int   mode;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t q4[$];
   exp_t q1[$];

   truth_table_sweeper_if if4();
   truth_table_sweeper_if if1();

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate models: 0xCF, stuck-at-1, stuck-at-0; the S=1 gate has one register of delay.
   always_comb begin
      case (mode)
         1:       g4 = 1'b1;
         2:       g4 = 1'b0;
         default: g4 = a4 | ~b4;
      endcase
   end

   always @(posedge clk) g1 <= a1 | ~b1;

   truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hCF)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start4),
      .busy_o     (busy4),
      .gate_in1_o (a4),
      .gate_in2_o (b4),
      .gate_in3_o (c4),
      .gate_out_i (g4),
      .res        (if4)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hCF)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start1),
      .busy_o     (busy1),
      .gate_in1_o (a1),
      .gate_in2_o (b1),
      .gate_in3_o (c1),
      .gate_out_i (g1),
      .res        (if1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop on every handshake, checking word, flag and valid-rise cycle.
   int  rise4 = -1, rise1 = -1;
   logic pv4 = 1'b0, pv1 = 1'b0;

   always begin
      exp_t e;
      @(negedge clk);
      #1;
      if (!rst) begin
         if (if4.res_valid && !pv4) rise4 = cyc;
         if (if4.res_valid && if4.res_ready) begin
            if (q4.size() == 0) begin
               chk("unexpected_result4", 32'(if4.res_table), 32'hFFFF_FFFF);
            end else begin
               e = q4.pop_front();
               chk("res_table4", 32'(if4.res_table), 32'(e.tbl));
               chk("res_match4", 32'(if4.res_match), 32'(e.m));
               chk("valid_cycle4", 32'(rise4), 32'(e.vc));
            end
         end
         if (if1.res_valid && !pv1) rise1 = cyc;
         if (if1.res_valid && if1.res_ready) begin
            if (q1.size() == 0) begin
               chk("unexpected_result1", 32'(if1.res_table), 32'hFFFF_FFFF);
            end else begin
               e = q1.pop_front();
               chk("res_table1", 32'(if1.res_table), 32'(e.tbl));
               chk("res_match1", 32'(if1.res_match), 32'(e.m));
               chk("valid_cycle1", 32'(rise1), 32'(e.vc));
            end
         end
      end
      pv4 = if4.res_valid;
      pv1 = if1.res_valid;
   end

   task automatic pulse4(output int c);
      c = cyc;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
   endtask

   task automatic push4(input logic [7:0] t, input logic m, input int vc);
      exp_t e;
      e.tbl = t; e.m = m; e.vc = vc;
      q4.push_back(e);
   endtask

   task automatic drain4();
      int n = 0;
      while ((q4.size() != 0 || busy4) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain4_timeout", 32'(n >= 300), 32'd0);
   endtask

   task automatic check_idle4(input string name);
      chk({name, "_busy"},  32'(busy4), 32'd0);
      chk({name, "_valid"}, 32'(if4.res_valid), 32'd0);
      chk({name, "_gates"}, 32'({a4, b4, c4}), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, n;
      exp_t e;
      rst = 1'b1; start4 = 1'b0; start1 = 1'b0; mode = 0;
      if4.res_ready = 1'b1;
      if1.res_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_idle4("reset");
      chk("reset_table", 32'(if4.res_table), 32'h00);
      chk("reset_match", 32'(if4.res_match), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Correct 0xCF gate: result at relative cycle 41, gates step every 5 cycles.
      pulse4(c);
      push4(8'hCF, 1'b1, c + 41);
      for (int rel = 1; rel <= 40; rel++) begin
         chk("gate_row", 32'({a4, b4, c4}), 32'((rel - 1) / 5));
         chk("busy_sweep", 32'(busy4), 32'd1);
         @(negedge clk);
      end
      chk("gates_result", 32'({a4, b4, c4}), 32'd0);
      drain4();
      check_idle4("after_cf");

      // Stuck-at models.
      mode = 1;
      pulse4(c);
      push4(8'hFF, 1'b0, c + 41);
      drain4();
      mode = 2;
      pulse4(c);
      push4(8'h00, 1'b0, c + 41);
      drain4();
      mode = 0;

      // Backpressure with an ignored start pulse in the RESULT window.
      if4.res_ready = 1'b0;
      pulse4(c);
      push4(8'hCF, 1'b1, c + 41);
      n = 0;
      while (!if4.res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_wait_timeout", 32'(n >= 100), 32'd0);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(if4.res_valid), 32'd1);
         chk("bp_table", 32'(if4.res_table), 32'hCF);
         chk("bp_match", 32'(if4.res_match), 32'd1);
         chk("bp_busy",  32'(busy4), 32'd1);
         start4 = (i == 3);
         @(negedge clk);
      end
      start4 = 1'b0;
      if4.res_ready = 1'b1;
      @(negedge clk);
      check_idle4("bp_after_hs");
      repeat (3) @(negedge clk);
      check_idle4("bp_no_queued_start");
      chk("bp_queue_empty", 32'(q4.size()), 32'd0);

      // Reset during row 3 settle, then a fresh sweep.
      pulse4(c);
      while (cyc < c + 17) @(negedge clk);
      chk("pre_reset_row3", 32'({a4, b4, c4}), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check_idle4("mid_reset");
      chk("mid_reset_table", 32'(if4.res_table), 32'h00);
      rst = 1'b0;
      @(negedge clk);
      check_idle4("post_reset_idle");
      pulse4(c);
      push4(8'hCF, 1'b1, c + 41);
      drain4();

      // SETTLE_CYCLES=1 with a register-delayed gate.
      c = cyc;
      e.tbl = 8'hCF; e.m = 1'b1; e.vc = c + 17;
      q1.push_back(e);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while ((q1.size() != 0 || busy1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain1_timeout", 32'(n >= 100), 32'd0);

      // start held for 100 cycles: sweeps accepted at relative edges 0, 42, 84.
      c = cyc;
      push4(8'hCF, 1'b1, c + 41);
      push4(8'hCF, 1'b1, c + 83);
      push4(8'hCF, 1'b1, c + 125);
      start4 = 1'b1;
      repeat (100) @(negedge clk);
      start4 = 1'b0;
      drain4();
      check_idle4("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Characterisation stage placed directly upstream of a 3-input Cello logic gate, such as the 0xCF gate (out = in1 | ~in2).
- Drives the gate's in1/in2/in3 through all 8 input rows, waits a settle period for each row, and samples the gate's output.
- Assembles the samples into an 8-bit Wolfram-style truth-table word and compares it against an expected code.
- Presents the word and the comparison result on a valid/ready result interface.

Parameters:
SETTLE_CYCLES, 4, cycles each row is held before sampling; legal range 1..255.
EXPECTED, 8'hCF, expected truth-table word for the match flag.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  one-cycle request to begin a sweep; accepted only in IDLE.
busy  output  1  high from the cycle after start is accepted until the state returns to IDLE.
gate_in1  output  1  drives gate in1 (row bit 2, MSB).
gate_in2  output  1  drives gate in2 (row bit 1).
gate_in3  output  1  drives gate in3 (row bit 0, LSB).
gate_out  input  1  gate output under test.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
res_table  output  8  captured truth-table word.
res_match  output  1  res_table == EXPECTED.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values (on any cycle with rst=1, including mid-sweep):
  - state = IDLE
  - busy = 0, res_valid = 0, res_match = 0
  - res_table = 8'h00
  - gate_in1..3 = 0
  - row counter and settle counter = 0
- States:
  - IDLE: start=1 → SETTLE with row=0, settle count=0. start=0 → stay in IDLE.
  - SETTLE: drive the current row. Count SETTLE_CYCLES cycles, then → SAMPLE.
  - SAMPLE: one cycle. Keep driving the row and capture gate_out into res_table[7-row].
    - If row==7 → RESULT.
    - Otherwise row+1 → SETTLE with the counter cleared.
  - RESULT: res_valid=1. res_table and res_match are held stable. On res_valid & res_ready → IDLE and res_valid drops the next cycle.
- Bit order: row 000 maps to res_table[7] and row 111 maps to res_table[0]. A correct 0xCF gate therefore yields 8'hCF.
- Gate drive:
  - {gate_in1,gate_in2,gate_in3} = row[2:0] in SETTLE and SAMPLE.
  - 3'b000 in IDLE and RESULT.
  - Driven from registers only (glitch-free).
- Timing: with start sampled high at cycle 0:
  - row r is driven from cycle r*(S+1)+1, where S = SETTLE_CYCLES;
  - row r is sampled at cycle r*(S+1)+S+1;
  - res_valid first asserts at cycle 8*(S+1)+1. For the default S=4 this is cycle 41.
- res_match: registered together with the final sample, so it is valid in the same cycle as res_valid.
- res_table is cleared to 8'h00 when a new start is accepted.
- start while busy (SETTLE, SAMPLE or RESULT) is ignored and not queued.
- start in the same cycle as the RESULT handshake is ignored. The block must be in IDLE to accept start.
- res_ready outside RESULT has no effect.
- Counter widths: row is 3 bits. The settle counter is 8 bits and never wraps because the state exits at SETTLE_CYCLES.

Decomposition:
- Package tt_sweep_pkg holds:
  - enum state_t {IDLE, SETTLE, SAMPLE, RESULT};
  - constant NUM_ROWS=8;
  - constant TABLE_W=8;
  - function row_bit(row) returning 7-row.
- One sub-module: settle_timer. It takes clk, rst, clear and enable, and produces a done output after SETTLE_CYCLES enabled cycles.
- The FSM, row counter and capture register stay in the top level.

Test Plan:
- Default parameters, behavioural 0xCF gate (out = in1|~in2), start pulse at cycle 0 → res_valid at cycle 41, res_table=8'hCF, res_match=1, and gate inputs sequence 000→111 in 5-cycle steps.
- Stuck-at-1 gate model → res_table=8'hFF, res_match=0. Stuck-at-0 model → 8'h00, res_match=0.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid, and pulse start during that window → res_valid, res_table and res_match stay stable, no new sweep starts, and after the handshake busy=0 and gate inputs=000.
- Reset asserted during row 3 SETTLE → next cycle is IDLE with busy=0, gate inputs=000, res_table=8'h00; a following start performs a full fresh sweep giving 8'hCF.
- SETTLE_CYCLES=1 with a gate model whose output is delayed by one register → still 8'hCF, with res_valid at cycle 17.
- start held high continuously for 100 cycles → back-to-back sweeps, each beginning only from IDLE after its handshake; with res_ready=1 the next sweep starts one cycle after returning to IDLE.
